// File: rtl/led_scan_decoder_pkg.sv
// Shared definitions for the LED scan decoder: glyph table, FSM encoding, default dwell.
// Pure declarations, no timing or flow control of its own.
package led_scan_decoder_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Segment patterns abcdefg (active-low), indexed by the hex value they display.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Anodes are legal when all are high (blank) or exactly one is low.
  function automatic logic anode_illegal(input logic [3:0] an);
    return !(an == 4'b1111 || an == 4'b1110 || an == 4'b1101 ||
             an == 4'b1011 || an == 4'b0111);
  endfunction

endpackage

// File: rtl/led_scan_decoder_seg7_to_nibble.sv
// Combinational 7-segment glyph to hex nibble lookup with a legal-glyph flag.
// Zero latency, no backpressure.
module seg7_to_nibble
  import led_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scan_decoder.sv
// Recovers the 16-bit word shown on a multiplexed 4-digit display; capture 1+STABLE_CYCLES
// after a pin change, frame_valid 1 cycle after the 4th capture; no backpressure, pulses only.
module led_scan_decoder
  import led_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [15:0] value,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        frame_err
);

  localparam logic [7:0] STABLE8 = 8'(STABLE_CYCLES);

  logic [11:0]      s;
  logic [11:0]      s_prev;
  state_t           state;
  state_t           state_nxt;
  logic [7:0]       count;
  logic [7:0]       count_nxt;
  logic             capture;
  logic             changed;
  logic             blank;
  logic             illegal;
  logic             illegal_new;
  logic             active;
  logic [1:0]       idx;
  logic [3:0]       nib;
  logic             nib_legal;
  logic [3:0]       mask;
  logic [3:0][3:0]  slot_nib;
  logic [3:0]       slot_dp;

  assign changed     = (s != s_prev);
  assign blank       = (s[11:8] == 4'b1111);
  assign illegal     = anode_illegal(s[11:8]);
  assign illegal_new = illegal && !anode_illegal(s_prev[11:8]);
  assign active      = !blank && !illegal;

  always_comb begin
    idx = 2'd0;
    case (s[11:8])
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  seg7_to_nibble u_lookup (
    .seg    (s[7:1]),
    .nibble (nib),
    .legal  (nib_legal)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    capture   = 1'b0;
    case (state)
      IDLE, SETTLE, HOLD: begin
        if (changed) begin
          state_nxt = active ? SETTLE : IDLE;
          count_nxt = 8'd1;
        end else if (state == SETTLE) begin
          count_nxt = count + 8'd1;
          // HOLD is only left on a change, so each dwell captures once.
          if (count_nxt == STABLE8) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s           <= '1;
      s_prev      <= '1;
      state       <= IDLE;
      count       <= '0;
      mask        <= '0;
      slot_nib    <= '0;
      slot_dp     <= '0;
      value       <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      s           <= {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};
      s_prev      <= s;
      state       <= state_nxt;
      count       <= count_nxt;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      frame_err   <= illegal_new;
      if (capture) begin
        if (nib_legal) begin
          slot_nib[idx] <= nib;
          slot_dp[idx]  <= ~s[0];
          mask[idx]     <= 1'b1;
        end else begin
          seg_err <= 1'b1;
          mask    <= '0;
        end
      end
      if (illegal_new) begin
        mask <= '0;
      end
      // A full mask can only appear on a capture edge; the next capture is at least two edges later.
      if (mask == 4'b1111) begin
        value       <= slot_nib;
        dp_out      <= slot_dp;
        frame_valid <= 1'b1;
        mask        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_decoder.sv
// Scoreboard bench for led_scan_decoder: directed scans push expected pulses, a negedge monitor checks them.
module tb_led_scan_decoder;

  localparam int SC = 4;

  localparam logic [6:0] GT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk = 1'b0;
  logic reset;
  logic an3, an2, an1, an0;
  logic a, b, c, d, e, f, g, dp;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic        frame_valid, seg_err, frame_err;

  always #5 clk = ~clk;

  led_scan_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .value(value), .dp_out(dp_out),
    .frame_valid(frame_valid), .seg_err(seg_err), .frame_err(frame_err)
  );

  // kind bits: [2]=frame_err [1]=seg_err [0]=frame_valid; cyc<0 means any cycle
  typedef struct {
    logic [2:0]  kind;
    logic [15:0] val;
    logic [3:0]  dpv;
    int          cyc;
  } ev_t;

  typedef struct {
    int          id;
    logic [15:0] val;
    logic [3:0]  dpv;
  } snap_t;

  ev_t   ev_q[$];
  snap_t snap_q[$];
  ev_t   ev_cur;
  snap_t snap_cur;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ev_n = 0;
  bit    done = 1'b0;

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dpl, input int n);
    {an3, an2, an1, an0} = an;
    {a, b, c, d, e, f, g} = seg;
    dp = dpl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dig(input int dn, input int hex, input bit dp_on, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << dn;
    drive(~oh, GT[hex], ~dp_on, n);
  endtask

  task automatic blank(input int n);
    drive(4'b1111, 7'h7F, 1'b1, n);
  endtask

  task automatic exp_ev(input logic [2:0] k, input logic [15:0] v, input logic [3:0] dv, input int cy);
    ev_q.push_back('{kind: k, val: v, dpv: dv, cyc: cy});
  endtask

  task automatic snap(input int id, input logic [15:0] v, input logic [3:0] dv);
    snap_q.push_back('{id: id, val: v, dpv: dv});
  endtask

  task automatic scan_word(input logic [15:0] w, input logic [3:0] dpm, input int periods);
    for (int p = 0; p < periods; p++) begin
      exp_ev(3'b001, w, dpm, -1);
      for (int k = 0; k < 4; k++) begin
        dig(k, int'(w[4*k +: 4]), dpm[k], 6);
        blank(1);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_valid || seg_err || frame_err) begin
      ev_n = ev_n + 1;
      total = total + 1;
      if (ev_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_pulse#%0d: got pulses=%b value=%h dp=%b at cycle %0d, want no pulse",
                 ev_n, {frame_err, seg_err, frame_valid}, value, dp_out, cyc);
      end else begin
        ev_cur = ev_q.pop_front();
        if ({frame_err, seg_err, frame_valid} != ev_cur.kind || value != ev_cur.val ||
            dp_out != ev_cur.dpv || (ev_cur.cyc >= 0 && cyc != ev_cur.cyc)) begin
          bad = bad + 1;
          $display("FAIL pulse#%0d: got pulses=%b value=%h dp=%b cycle=%0d, want pulses=%b value=%h dp=%b cycle=%0d",
                   ev_n, {frame_err, seg_err, frame_valid}, value, dp_out, cyc,
                   ev_cur.kind, ev_cur.val, ev_cur.dpv, ev_cur.cyc);
        end
      end
    end
    if (snap_q.size() != 0) begin
      snap_cur = snap_q.pop_front();
      total = total + 1;
      if (value != snap_cur.val || dp_out != snap_cur.dpv || frame_valid || seg_err || frame_err) begin
        bad = bad + 1;
        $display("FAIL snapshot%0d: got value=%h dp=%b pulses=%b, want value=%h dp=%b pulses=000",
                 snap_cur.id, value, dp_out, {frame_err, seg_err, frame_valid}, snap_cur.val, snap_cur.dpv);
      end
    end
    if (done) begin
      total = total + 1;
      if (ev_q.size() != 0) begin
        bad = bad + 1;
        $display("FAIL missing_pulses: got %0d expected pulses still outstanding, want 0", ev_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    if (cyc > 20000) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL watchdog: got cycle %0d without completion, want completion before 20000", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    reset = 1'b0;
    {an3, an2, an1, an0} = 4'b1111;
    {a, b, c, d, e, f, g} = 7'h7F;
    dp = 1'b1;
    blank(3);
    snap(1, 16'h0000, 4'b0000);
    blank(2);
    reset = 1'b1;
    blank(2);
    snap(2, 16'h0000, 4'b0000);
    blank(1);

    // digits 1,2,3,4; frame_valid expected SC+3 negedges after the digit-3 pins change
    dig(0, 1, 1'b0, 8);
    dig(1, 2, 1'b0, 8);
    dig(2, 3, 1'b0, 8);
    exp_ev(3'b001, 16'h4321, 4'b0000, cyc + SC + 3);
    dig(3, 4, 1'b0, 8);
    blank(2);
    snap(3, 16'h4321, 4'b0000);

    // short dwell on the last digit must not complete the frame
    dig(0, 5, 1'b0, 8);
    dig(1, 6, 1'b0, 8);
    dig(2, 7, 1'b0, 8);
    dig(3, 8, 1'b0, SC - 1);
    blank(6);
    snap(4, 16'h4321, 4'b0000);
    exp_ev(3'b001, 16'h8765, 4'b0000, -1);
    dig(3, 8, 1'b0, 8);
    blank(2);
    snap(5, 16'h8765, 4'b0000);

    // illegal glyph on an2 aborts the partial frame
    dig(0, 9, 1'b0, 8);
    dig(1, 10, 1'b0, 8);
    exp_ev(3'b010, 16'h8765, 4'b0000, -1);
    drive(4'b1011, 7'b1111111, 1'b1, 8);
    dig(2, 14, 1'b0, 8);
    dig(3, 11, 1'b0, 8);
    blank(2);
    snap(6, 16'h8765, 4'b0000);
    dig(0, 12, 1'b0, 8);
    exp_ev(3'b001, 16'hBEDC, 4'b0000, -1);
    dig(1, 13, 1'b0, 8);
    blank(2);
    snap(7, 16'hBEDC, 4'b0000);

    // two anodes low: one frame_err, mask cleared, then an all-F scan with dp on
    dig(0, 1, 1'b0, 8);
    dig(1, 1, 1'b0, 8);
    dig(2, 1, 1'b0, 8);
    exp_ev(3'b100, 16'hBEDC, 4'b0000, -1);
    drive(4'b1100, GT[8], 1'b1, 5);
    drive(4'b0011, GT[8], 1'b1, 5);
    blank(3);
    dig(3, 15, 1'b1, 8);
    dig(0, 15, 1'b1, 8);
    dig(1, 15, 1'b1, 8);
    exp_ev(3'b001, 16'hFFFF, 4'b1111, -1);
    dig(2, 15, 1'b1, 8);
    blank(2);
    snap(8, 16'hFFFF, 4'b1111);

    // reset after three captures discards them
    dig(0, 2, 1'b0, 8);
    dig(1, 3, 1'b0, 8);
    dig(2, 4, 1'b0, 8);
    reset = 1'b0;
    blank(3);
    snap(9, 16'h0000, 4'b0000);
    blank(1);
    reset = 1'b1;
    blank(2);
    snap(10, 16'h0000, 4'b0000);
    dig(3, 12, 1'b0, 8);
    dig(0, 8, 1'b0, 8);
    dig(1, 9, 1'b0, 8);
    exp_ev(3'b001, 16'hCA98, 4'b0000, -1);
    dig(2, 10, 1'b0, 8);
    blank(2);
    snap(11, 16'hCA98, 4'b0000);

    // free-running driver scans with blanking between digits
    scan_word(16'h1234, 4'b0101, 2);
    scan_word(16'hDEAD, 4'b1000, 2);
    scan_word(16'h0F0F, 4'b0010, 1);
    blank(4);
    snap(12, 16'h0F0F, 4'b0010);
    blank(2);
    done = 1'b1;
  end

endmodule
